// File: rtl/present_pkg.sv
// Shared widths and state encoding for the PRESENT decipher front end.
// No ports; imported by present_dec_loader and nibble_shift_reg.
package present_pkg;

  localparam int NIBBLE_W      = 4;
  localparam int BLOCK_W       = 16;
  localparam int KEY_W         = 20;
  localparam int BLOCK_NIBBLES = 4;
  localparam int KEY_NIBBLES   = 5;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_shift_reg.sv
// Nibble-wide shift register, MSB-first: each enabled edge moves the contents
// up by one nibble and inserts the new nibble at the bottom.
// Ports:
//   clk, rst_n  clock, async active-low reset (clears contents)
//   shift_en    shift in nibble this edge
//   nibble      incoming nibble
//   q           current register contents
module nibble_shift_reg
  import present_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en,
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [WIDTH-1:0]    q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-NIBBLE_W-1:0], nibble};
    end
  end

endmodule

// File: rtl/present_dec_loader.sv
// Sequential front end for a combinational PRESENT decipher: assembles the
// key and ciphertext from nibble streams, holds them on the decipher inputs,
// waits SETTLE_CYCLES, then captures the plaintext for a valid/ready consumer.
//
// state  | meaning
// LOAD   | accepting key / ciphertext nibbles
// SETTLE | decipher inputs frozen, counting down the settle window
// HOLD   | plaintext captured, waiting for out_ready
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready/in_is_key/in_nibble  nibble input stream
//   dec_key, dec_ctext               to decipher datapath
//   dec_ptext                        from decipher datapath
//   out_valid/out_ready/out_ptext    result handshake
//   key_valid                        a full key is loaded
module present_dec_loader
  import present_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_is_key,
  input  logic [NIBBLE_W-1:0] in_nibble,
  output logic [KEY_W-1:0]    dec_key,
  output logic [BLOCK_W-1:0]  dec_ctext,
  input  logic [BLOCK_W-1:0]  dec_ptext,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLOCK_W-1:0]  out_ptext,
  output logic                key_valid
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  state_t           state;
  logic [2:0]       key_cnt;
  logic [2:0]       ct_cnt;
  logic [CNT_W-1:0] settle_cnt;
  logic             accept;
  logic             key_shift;
  logic             ct_shift;

  // Handshake outputs depend on registered state only.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == HOLD);

  assign accept    = in_valid & in_ready;
  assign key_shift = accept & in_is_key;
  // Ciphertext without a loaded key is accepted but dropped.
  assign ct_shift  = accept & ~in_is_key & key_valid;

  nibble_shift_reg #(.WIDTH(KEY_W)) u_key_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (key_shift),
    .nibble   (in_nibble),
    .q        (dec_key)
  );

  nibble_shift_reg #(.WIDTH(BLOCK_W)) u_ctext_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (ct_shift),
    .nibble   (in_nibble),
    .q        (dec_ctext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      key_cnt    <= '0;
      ct_cnt     <= '0;
      settle_cnt <= '0;
      key_valid  <= 1'b0;
      out_ptext  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (key_shift) begin
            // A key nibble abandons any partially loaded block.
            ct_cnt <= '0;
            if (key_cnt == 3'd0) key_valid <= 1'b0;
            if (key_cnt == 3'(KEY_NIBBLES - 1)) begin
              key_cnt   <= '0;
              key_valid <= 1'b1;
            end else begin
              key_cnt <= key_cnt + 3'd1;
            end
          end else if (ct_shift) begin
            if (ct_cnt == 3'(BLOCK_NIBBLES - 1)) begin
              ct_cnt     <= '0;
              settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
              state      <= SETTLE;
            end else begin
              ct_cnt <= ct_cnt + 3'd1;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            out_ptext <= dec_ptext;
            state     <= HOLD;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_present_dec_loader.sv
module tb_present_dec_loader;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_key;
  logic [3:0]  in_nibble;
  logic [19:0] dec_key;
  logic [15:0] dec_ctext;
  logic [15:0] dec_ptext;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ptext;
  logic        key_valid;

  int checks = 0;
  int errors = 0;
  int results = 0;

  // Stand-in for the combinational decipher: any fixed mixing of key and
  // ciphertext lets the bench predict the captured value.
  function automatic logic [15:0] ref_dec(input logic [15:0] c, input logic [19:0] k);
    return c ^ k[15:0] ^ {k[19:16], k[19:16], 8'h5A};
  endfunction

  assign dec_ptext = ref_dec(dec_ctext, dec_key);

  present_dec_loader #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_is_key (in_is_key),
    .in_nibble (in_nibble),
    .dec_key   (dec_key),
    .dec_ctext (dec_ctext),
    .dec_ptext (dec_ptext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ptext (out_ptext),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && out_valid && out_ready) results++;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic k, input logic [3:0] n);
    int t = 0;
    while (!in_ready && t < 50) begin cyc(); t++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL send_wait in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_is_key = k; in_nibble = n;
    cyc();
    in_valid = 1'b0; in_is_key = 1'b0; in_nibble = 4'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_is_key = 1'b0; in_nibble = 4'h0; out_ready = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || key_valid !== 1'b0 ||
        out_ptext !== 16'h0 || dec_key !== 20'h0 || dec_ctext !== 16'h0) begin
      errors++;
      $display("FAIL %s rdy=%b ov=%b kv=%b pt=%h key=%h ct=%h required 1 0 0 0000 00000 0000",
               tag, in_ready, out_valid, key_valid, out_ptext, dec_key, dec_ctext);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_vals("reset_values");
  endtask

  task automatic test_key_load();
    send(1'b1, 4'h1); send(1'b1, 4'h2); send(1'b1, 4'h3); send(1'b1, 4'h4);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++; $display("FAIL key_valid_early actual=%b required 0", key_valid);
    end
    send(1'b1, 4'h5);
    checks++;
    if (key_valid !== 1'b1) begin
      errors++; $display("FAIL key_valid_set actual=%b required 1", key_valid);
    end
    checks++;
    if (dec_key !== 20'h12345) begin
      errors++; $display("FAIL dec_key actual=%h required 12345", dec_key);
    end
  endtask

  task automatic test_block_decode();
    send(1'b0, 4'hA); send(1'b0, 4'hB); send(1'b0, 4'hC);
    in_valid = 1'b1; in_is_key = 1'b0; in_nibble = 4'hD;
    cyc();  // edge N
    in_valid = 1'b0; in_nibble = 4'h0;
    checks++;
    if (dec_ctext !== 16'hABCD) begin
      errors++; $display("FAIL dec_ctext actual=%h required abcd", dec_ctext);
    end
    for (int i = 1; i <= S; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL settle_%0d rdy=%b ov=%b required 0 0", i, in_ready, out_valid);
      end
      cyc();
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL capture_latency out_valid=%b required 1", out_valid);
    end
    checks++;
    if (out_ptext !== ref_dec(16'hABCD, 20'h12345)) begin
      errors++; $display("FAIL out_ptext actual=%h required %h", out_ptext, ref_dec(16'hABCD, 20'h12345));
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_pt;
    int r0;
    exp_pt = ref_dec(16'hABCD, 20'h12345);
    r0 = results;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_ptext !== exp_pt || in_ready !== 1'b0) begin
        errors++; $display("FAIL backpressure_%0d ov=%b pt=%h rdy=%b required 1 %h 0",
                           i, out_valid, out_ptext, in_ready, exp_pt);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL release ov=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    cyc(); cyc();
    checks++;
    if (results - r0 !== 1) begin
      errors++; $display("FAIL bp_result_count actual=%0d required 1", results - r0);
    end
  endtask

  task automatic test_partial_abort();
    int r0;
    int t;
    send(1'b0, 4'hA); send(1'b0, 4'hB);
    send(1'b1, 4'hF);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++; $display("FAIL abort_key_valid_clear actual=%b required 0", key_valid);
    end
    send(1'b1, 4'hF); send(1'b1, 4'hF); send(1'b1, 4'hF); send(1'b1, 4'hF);
    checks++;
    if (dec_key !== 20'hFFFFF || key_valid !== 1'b1) begin
      errors++; $display("FAIL abort_key key=%h kv=%b required fffff 1", dec_key, key_valid);
    end
    checks++;
    if (dec_ctext !== 16'hCDAB) begin
      errors++; $display("FAIL abort_ctext_kept actual=%h required cdab", dec_ctext);
    end
    r0 = results;
    out_ready = 1'b1;
    send(1'b0, 4'h1); send(1'b0, 4'h2); send(1'b0, 4'h3);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_no_early_settle in_ready=%b required 1", in_ready);
    end
    send(1'b0, 4'h4);
    t = 0;
    while (!out_valid && t < 30) begin cyc(); t++; end
    checks++;
    if (out_valid !== 1'b1 || dec_ctext !== 16'h1234 || out_ptext !== ref_dec(16'h1234, 20'hFFFFF)) begin
      errors++; $display("FAIL abort_capture ov=%b ct=%h pt=%h required 1 1234 %h",
                         out_valid, dec_ctext, out_ptext, ref_dec(16'h1234, 20'hFFFFF));
    end
    for (int i = 0; i < 12; i++) cyc();
    out_ready = 1'b0;
    checks++;
    if (results - r0 !== 1) begin
      errors++; $display("FAIL abort_result_count actual=%0d required 1", results - r0);
    end
  endtask

  task automatic test_no_key();
    do_reset();
    send(1'b0, 4'h1); send(1'b0, 4'h2); send(1'b0, 4'h3); send(1'b0, 4'h4);
    for (int i = 0; i < S + 3; i++) begin
      checks++;
      if (dec_ctext !== 16'h0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL no_key_%0d ct=%h rdy=%b ov=%b required 0000 1 0",
                           i, dec_ctext, in_ready, out_valid);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid_settle();
    send(1'b1, 4'h9); send(1'b1, 4'h8); send(1'b1, 4'h7); send(1'b1, 4'h6); send(1'b1, 4'h5);
    send(1'b0, 4'h1); send(1'b0, 4'h2); send(1'b0, 4'h3); send(1'b0, 4'h4);
    cyc();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_settle_entry in_ready=%b required 0", in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("reset_async");
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < S + 4; i++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL post_reset_%0d ov=%b rdy=%b required 0 1", i, out_valid, in_ready);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_block_decode();
    test_backpressure();
    test_partial_abort();
    test_no_key();
    test_reset_mid_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/present_dec_loader.md
# present_dec_loader

Sequential front end for the combinational PRESENT decipher datapath (16-bit block, 20-bit master key). Accepts the master key and ciphertext as 4-bit nibble streams over a valid/ready handshake and holds the assembled key and ciphertext stable on the decipher inputs. Waits a programmable multicycle settle window, then captures the plaintext into an output register presented on a valid/ready handshake. One block is in flight at a time.

## Interface
- SETTLE_CYCLES, 2, cycles between the last ciphertext nibble edge and the plaintext capture edge; legal range ≥1
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  nibble on in_nibble is valid
- in_ready  out  1  loader accepts a nibble this cycle
- in_is_key  in  1  1: nibble is a key nibble; 0: ciphertext nibble
- in_nibble  in  4  data nibble, MSB-first order
- dec_key  out  20  master key to the decipher
- dec_ctext  out  16  ciphertext to the decipher
- dec_ptext  in  16  plaintext from the decipher (combinational)
- out_valid  out  1  out_ptext holds a captured result
- out_ready  in  1  consumer accepts the result
- out_ptext  out  16  captured plaintext
- key_valid  out  1  a complete 5-nibble key is loaded

## Operation
- Transfer occurs on a rising edge with in_valid & in_ready; result transfer with out_valid & out_ready.
- States: LOAD (in_ready=1), SETTLE (in_ready=0, settle counter running), HOLD (out_valid=1, in_ready=0).
- Key nibble (any time in LOAD): shifted in at dec_key[3:0], previous contents move up 4 bits; key nibble counter increments.
  - First nibble of a key load clears key_valid. The 5th sets key_valid and clears the key counter.
  - A key nibble arriving while a ciphertext block is partial discards the partial block (ctext counter to 0; dec_ctext contents untouched).
- Ciphertext nibble in LOAD:
  - With key_valid=0: accepted and dropped. No counter change.
  - With key_valid=1: shifted in at dec_ctext[3:0], MSB first; ctext counter increments.
  - On the 4th nibble: counter clears, settle counter loads SETTLE_CYCLES-1, state goes to SETTLE.
- SETTLE: counter decrements each cycle. In the cycle counter==0, the next edge loads out_ptext <= dec_ptext, and state goes to HOLD.
- HOLD: on out_ready, out_valid drops, and state returns to LOAD at that edge.
- Partial key load in LOAD with key_valid=0 and a key counter of 1–4: key counter continues on further key nibbles. No timeout.
- dec_key and dec_ctext do not change in SETTLE or HOLD.

## Timing
- Reset values: state LOAD; in_ready=1, out_valid=0, key_valid=0, out_ptext=0, dec_key=0, dec_ctext=0; all counters 0.
- Capture latency:
  - 4th ciphertext nibble accepted at edge N.
  - dec_ctext is final after edge N.
  - out_ptext is captured at edge N+SETTLE_CYCLES, and out_valid=1 from that edge.
- Next nibble acceptance: in_ready returns 1 on the edge after the out_ready handshake. Minimum block period is 4+SETTLE_CYCLES+1 cycles with out_ready held high.
- out_valid, out_ptext, and in_ready are registered, or derived from registered state only. There is no combinational path from in_valid or out_ready to any output.
- rst_n asserted mid-operation: immediate return to reset values; any partial key, ciphertext, or captured result is lost.
- in_is_key is ignored when in_valid=0.

## Structure
- Shared package present_pkg:
  - NIBBLE_W=4, BLOCK_W=16, KEY_W=20
  - BLOCK_NIBBLES=4, KEY_NIBBLES=5
  - state enum {LOAD, SETTLE, HOLD}
- One sub-module: nibble_shift_reg, parameterized by width, with async reset, shift-enable, and a nibble input. Instantiated twice: key and ciphertext.
- Settle counter width is $clog2(SETTLE_CYCLES+1).

## Test plan
- Reset and key load:
  - Stimulus: reset; key nibbles 1,2,3,4,5.
  - Response: key_valid rises after the 5th; dec_key=0x12345.
- Block decode:
  - Stimulus: ciphertext A,B,C,D.
  - Response: dec_ctext=0xABCD; out_valid exactly SETTLE_CYCLES edges after the 4th nibble; out_ptext equals a present_decipher reference instance output for (0xABCD, 0x12345); in_ready=0 throughout SETTLE and HOLD.
- Backpressure:
  - Stimulus: out_ready held 0 for 10 cycles.
  - Response: out_valid and out_ptext stay stable; in_ready=0; one result accepted when out_ready rises.
- No key:
  - Stimulus: after reset, ciphertext nibbles 1,2,3,4 with no key.
  - Response: all accepted; dec_ctext stays 0; state stays LOAD; out_valid never asserts.
- Partial-block abort:
  - Stimulus: ciphertext A,B, then 5 key nibbles F,F,F,F,F, then ciphertext 1,2,3,4.
  - Response: dec_key=0xFFFFF; exactly one result; capture occurs with dec_ctext=0x1234 (the shift register retains the discarded A,B, but they are shifted out by the 4 new nibbles).
- Reset mid-SETTLE:
  - Stimulus: rst_n pulsed low during SETTLE with SETTLE_CYCLES=4.
  - Response: all outputs at reset values in the same cycle; no out_valid afterwards.
